// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Opcode values follow the RV32I base encoding.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] i_instr_id,
  input  logic [31:0] i_instr_ex,
  input  logic        i_rd_wren_ex,
  input  logic [1:0]  i_wb_sel_ex,
  output logic        o_load_use
);

  logic [6:0] opc_id_s;
  logic [4:0] rs1_id_s;
  logic [4:0] rs2_id_s;
  logic [4:0] rd_ex_s;
  logic       rs1_used_s;
  logic       rs2_used_s;
  logic       unused_s;

  assign opc_id_s = i_instr_id[6:0];
  assign rs1_id_s = i_instr_id[19:15];
  assign rs2_id_s = i_instr_id[24:20];
  assign rd_ex_s  = i_instr_ex[11:7];
  assign unused_s = ^{i_instr_id[31:25], i_instr_id[14:7], i_instr_ex[31:12], i_instr_ex[6:0]};

  // Which ID source fields are real register reads for this opcode
  always_comb begin
    rs1_used_s = 1'b1;
    rs2_used_s = 1'b0;
    case (opc_id_s)
      OPC_LUI, OPC_AUIPC, OPC_JAL: rs1_used_s = 1'b0;
      OPC_OP, OPC_STORE, OPC_BRANCH: rs2_used_s = 1'b1;
      default: begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
      end
    endcase
  end

  assign o_load_use = i_rd_wren_ex && (i_wb_sel_ex == WB_MEM) && (rd_ex_s != 5'd0) &&
                      ((rs1_used_s && (rs1_id_s == rd_ex_s)) ||
                       (rs2_used_s && (rs2_id_s == rd_ex_s)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: drives stage
// register enables/clears and counts stall cycles and redirect flushes.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_instr_id,
  input  logic [31:0]      i_instr_ex,
  input  logic             i_rd_wren_ex,
  input  logic [1:0]       i_wb_sel_ex,
  input  logic             i_pc_sel_ex,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_en_pc,
  output logic             o_en_if,
  output logic             o_en_id,
  output logic             o_en_ex,
  output logic             o_en_mem,
  output logic             o_clr_if_n,
  output logic             o_clr_id_n,
  output logic             o_clr_ex_n,
  output logic             o_clr_mem_n,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [ICW-1:0]   init_q, init_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [4:0]       en_s;     // {pc, if, id, ex, mem}
  logic [3:0]       clr_n_s;  // {if, id, ex, mem}
  logic             mem_wait_s;
  logic             load_use_s;

  hazard_detect u_hazard_detect (
    .i_instr_id   (i_instr_id),
    .i_instr_ex   (i_instr_ex),
    .i_rd_wren_ex (i_rd_wren_ex),
    .i_wb_sel_ex  (i_wb_sel_ex),
    .o_load_use   (load_use_s)
  );

  // Priority: memory wait, then redirect, then load-use bubble
  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    en_s       = 5'b00000;
    clr_n_s    = 4'b0000;
    mem_wait_s = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_q == INIT_LAST) begin
          state_d = ST_RUN;
          init_d  = '0;
        end else begin
          init_d = init_q + ICW'(1);
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        mem_wait_s = (state_q == ST_MEM_WAIT) ? !i_mem_ready : (i_mem_req && !i_mem_ready);
        if (mem_wait_s) begin
          en_s    = 5'b00000;
          clr_n_s = 4'b1111;
          state_d = ST_MEM_WAIT;
        end else if (i_pc_sel_ex) begin
          en_s    = 5'b11111;
          clr_n_s = 4'b0011;
          flush_d = flush_q + CNT_W'(1);
          state_d = ST_RUN;
        end else if (load_use_s) begin
          en_s    = 5'b00111;
          clr_n_s = 4'b1011;
          state_d = ST_RUN;
        end else begin
          en_s    = 5'b11111;
          clr_n_s = 4'b1111;
          state_d = ST_RUN;
        end
        if (!en_s[4]) begin
          stall_d = stall_q + CNT_W'(1);
        end else begin
          stall_d = stall_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        init_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      init_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign {o_en_pc, o_en_if, o_en_id, o_en_ex, o_en_mem} = en_s;
  assign {o_clr_if_n, o_clr_id_n, o_clr_ex_n, o_clr_mem_n} = clr_n_s;
  assign o_state     = state_q;
  assign o_stall_cnt = stall_q;
  assign o_flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random
// traffic, checked against a behavioural model of the control rules.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int INIT_CYCLES = 4;
  localparam int CNT_W       = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] instr_id, instr_ex;
  logic        rd_wren_ex, pc_sel_ex, mem_req, mem_ready;
  logic [1:0]  wb_sel_ex;
  logic        en_pc, en_if, en_id, en_ex, en_mem;
  logic        clr_if_n, clr_id_n, clr_ex_n, clr_mem_n;
  logic [1:0]  state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr_id(instr_id), .i_instr_ex(instr_ex),
    .i_rd_wren_ex(rd_wren_ex), .i_wb_sel_ex(wb_sel_ex), .i_pc_sel_ex(pc_sel_ex),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_en_pc(en_pc), .o_en_if(en_if), .o_en_id(en_id), .o_en_ex(en_ex), .o_en_mem(en_mem),
    .o_clr_if_n(clr_if_n), .o_clr_id_n(clr_id_n), .o_clr_ex_n(clr_ex_n), .o_clr_mem_n(clr_mem_n),
    .o_state(state), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  en;
    logic [3:0]  clr;
    logic [1:0]  st;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Reference model state: mode 0=INIT 1=RUN 2=MEM_WAIT
  bit          mvalid = 1'b0;
  int          mmode = 0;
  int          minit = 0;
  logic [31:0] mstall = 32'd0;
  logic [31:0] mflush = 32'd0;

  logic [6:0] ops [9] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                          OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};

  function automatic logic [31:0] mk(logic [6:0] op, int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
  endfunction

  function automatic bit reads_rs1(logic [6:0] op);
    return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
  endfunction

  function automatic bit reads_rs2(logic [6:0] op);
    return op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH;
  endfunction

  function automatic bit load_use_ref(logic [31:0] id, logic [31:0] ex, logic wren, logic [1:0] wb);
    logic [6:0] op;
    int rd, r1, r2;
    op = id[6:0];
    rd = int'(ex[11:7]);
    r1 = int'(id[19:15]);
    r2 = int'(id[24:20]);
    if (!wren || wb != WB_MEM || rd == 0) return 1'b0;
    return (reads_rs1(op) && r1 == rd) || (reads_rs2(op) && r2 == rd);
  endfunction

  task automatic chk(string name, int cyc, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; pushes the expected response, advances the model
  task automatic step(logic r, logic [31:0] id, logic [31:0] ex, logic wren, logic [1:0] wb,
                      logic pcsel, logic req, logic rdy);
    exp_t e;
    bit wait_c;
    rst = r; instr_id = id; instr_ex = ex; rd_wren_ex = wren; wb_sel_ex = wb;
    pc_sel_ex = pcsel; mem_req = req; mem_ready = rdy;
    if (mvalid) begin
      e.cyc = cycle; e.st = 2'(mmode); e.stall = mstall; e.flush = mflush;
      if (mmode == 0) begin
        e.en = 5'b00000; e.clr = 4'b0000;
        minit++;
        if (minit == INIT_CYCLES) mmode = 1;
      end else begin
        wait_c = (mmode == 2) ? !rdy : (req && !rdy);
        if (wait_c) begin
          e.en = 5'b00000; e.clr = 4'b1111; mmode = 2;
        end else if (pcsel) begin
          e.en = 5'b11111; e.clr = 4'b0011; mflush++; mmode = 1;
        end else if (load_use_ref(id, ex, wren, wb)) begin
          e.en = 5'b00111; e.clr = 4'b1011; mmode = 1;
        end else begin
          e.en = 5'b11111; e.clr = 4'b1111; mmode = 1;
        end
        if (!e.en[4]) mstall++;
      end
      q.push_back(e);
    end
    if (r) begin
      mvalid = 1'b1; mmode = 0; minit = 0; mstall = 32'd0; mflush = 32'd0;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, NOP, NOP, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("enables", e.cyc, {27'd0, en_pc, en_if, en_id, en_ex, en_mem}, {27'd0, e.en});
      chk("clears", e.cyc, {28'd0, clr_if_n, clr_id_n, clr_ex_n, clr_mem_n}, {28'd0, e.clr});
      chk("state", e.cyc, {30'd0, state}, {30'd0, e.st});
      chk("stall_cnt", e.cyc, stall_cnt, e.stall);
      chk("flush_cnt", e.cyc, flush_cnt, e.flush);
    end
  end

  logic [31:0] lw_x5, add_x6, lui_x5, lw_x0, add_x0;

  initial begin
    rst = 1'b1; instr_id = NOP; instr_ex = NOP; rd_wren_ex = 1'b0; wb_sel_ex = WB_ALU;
    pc_sel_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    lw_x5  = mk(OPC_LOAD, 5, 1, 0);
    add_x6 = mk(OPC_OP, 6, 5, 1);
    lui_x5 = mk(OPC_LUI, 5, 5, 5);
    lw_x0  = mk(OPC_LOAD, 0, 1, 0);
    add_x0 = mk(OPC_OP, 6, 0, 0);

    // reset held 3 cycles, then drain
    for (int i = 0; i < 3; i++) step(1'b1, NOP, NOP, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b0);
    idle(6);
    // load-use, then the cycle after, then non-hazards
    step(1'b0, add_x6, lw_x5, 1'b1, WB_MEM, 1'b0, 1'b0, 1'b0);
    step(1'b0, add_x6, NOP, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b0);
    step(1'b0, lui_x5, lw_x5, 1'b1, WB_MEM, 1'b0, 1'b0, 1'b0);
    step(1'b0, add_x0, lw_x0, 1'b1, WB_MEM, 1'b0, 1'b0, 1'b0);
    // redirect overriding load-use
    step(1'b0, add_x6, lw_x5, 1'b1, WB_MEM, 1'b1, 1'b0, 1'b0);
    idle(1);
    // memory wait 3 cycles then ready
    for (int i = 0; i < 3; i++) step(1'b0, NOP, NOP, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b0);
    step(1'b0, NOP, NOP, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b1);
    idle(1);
    // memory wait with redirect held
    for (int i = 0; i < 3; i++) step(1'b0, NOP, NOP, 1'b0, WB_ALU, 1'b1, 1'b1, 1'b0);
    step(1'b0, NOP, NOP, 1'b0, WB_ALU, 1'b1, 1'b1, 1'b1);
    idle(1);
    // reset during MEM_WAIT
    step(1'b0, NOP, NOP, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b0);
    step(1'b0, NOP, NOP, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b0);
    step(1'b1, NOP, NOP, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b0);
    idle(6);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] id_r, ex_r;
      id_r = mk(ops[$urandom_range(0, 8)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      ex_r = mk(ops[$urandom_range(0, 8)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      step(($urandom_range(0, 299) == 0), id_r, ex_r, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the enable and active-low clear inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It resolves load-use hazards, LSU memory wait states and EX-stage redirects, and holds the pipeline in a drain sequence after reset. It also exposes stall and flush event counters for debug.

Parameters:
INIT_CYCLES, 4, cycles after reset release during which all stage registers are held cleared
CNT_W, 32, width of the performance counters

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_instr_id  in  32  instruction word in ID stage (IF/ID output)
i_instr_ex  in  32  instruction word in EX stage (ID/EX output)
i_rd_wren_ex  in  1  EX instruction writes rd
i_wb_sel_ex  in  2  EX writeback select; WB_MEM marks a load
i_pc_sel_ex  in  1  EX redirect (taken branch/jump)
i_mem_req  in  1  MEM-stage instruction is an active load/store
i_mem_ready  in  1  LSU completes the MEM-stage access this cycle
o_en_pc  out  1  PC register enable
o_en_if  out  1  IF/ID enable
o_en_id  out  1  ID/EX enable
o_en_ex  out  1  EX/MEM enable
o_en_mem  out  1  MEM/WB enable
o_clr_if_n  out  1  IF/ID clear (0 = load NOP 0x00000013)
o_clr_id_n  out  1  ID/EX clear
o_clr_ex_n  out  1  EX/MEM clear
o_clr_mem_n  out  1  MEM/WB clear
o_state  out  2  current FSM state
o_stall_cnt  out  CNT_W  cycles with o_en_pc=0 while in RUN or MEM_WAIT
o_flush_cnt  out  CNT_W  number of redirect flushes applied

Behaviour:
- FSM states: INIT=0, RUN=1, MEM_WAIT=2. Registered; outputs are combinational from state and inputs.
- Reset (i_rst=1 at a clock edge): state=INIT, init counter=0, o_stall_cnt=0, o_flush_cnt=0. While in INIT, all o_en_*=0 and all o_clr_*_n=0. Reset mid-operation aborts any state immediately at the next edge.
- INIT: counter increments each cycle. After INIT_CYCLES cycles it moves to RUN. First RUN cycle = reset deassert edge + INIT_CYCLES.
- RUN, default: all enables=1, all clears=1.
- MEM wait, highest priority: i_mem_req=1 and i_mem_ready=0 -> all enables=0 and state->MEM_WAIT. The condition is evaluated in the same cycle, so there is no skid.
- MEM_WAIT: all enables=0 and clears=1 until i_mem_ready=1. In that cycle, RUN-cycle rules apply (redirect/load-use evaluated) and state->RUN.
- Redirect, second priority: i_pc_sel_ex=1 and no mem wait -> all enables=1, o_clr_if_n=0, o_clr_id_n=0. The two wrong-path instructions become NOPs. o_flush_cnt increments by 1. A redirect overrides load-use in the same cycle.
- Load-use, third priority. Hazard exists when all of the following hold:
  - i_rd_wren_ex=1;
  - i_wb_sel_ex=WB_MEM;
  - rd_ex != 0;
  - rd_ex matches a used ID source register.
  rs1 is used by every opcode except LUI, AUIPC, JAL. rs2 is used by OP, STORE, BRANCH.
  Response for one cycle: o_en_pc=0, o_en_if=0, o_en_id=1, o_clr_id_n=0 (bubble into EX), others enabled.
  The following cycle has no hazard because the load has moved to MEM; no state is needed.
- o_stall_cnt increments in every RUN/MEM_WAIT cycle with o_en_pc=0. o_stall_cnt and o_flush_cnt wrap at 2^CNT_W silently.
- Field extraction: rd=[11:7], rs1=[19:15], rs2=[24:20], opcode=[6:0].

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum;
  - WB_MEM/WB_ALU/WB_PC4 encodings for wb_sel;
  - RV32I opcode constants;
  - NOP constant 32'h0000_0013.
- One sub-module, hazard_detect (combinational): instruction fields -> load_use flag. Reusable by a future forwarding unit.

Test Plan:
- Reset held 3 cycles, then released with INIT_CYCLES=4 -> state=INIT and all enables/clears 0 for exactly 4 cycles; state=RUN on the 5th; both counters 0.
- EX=lw x5 (wb_sel=WB_MEM, rd_wren=1), ID=add x6,x5,x1 -> one cycle with en_pc=en_if=0, clr_id_n=0; stall_cnt=1. Repeat with ID=lui x5 and with rd=x0 -> no stall.
- Redirect: i_pc_sel_ex=1 while a load-use hazard is also present -> clr_if_n=clr_id_n=0, all enables 1, no stall, flush_cnt=1.
- MEM wait: i_mem_req=1, i_mem_ready=0 for 3 cycles then 1 -> all enables 0 for 3 cycles; state=MEM_WAIT; stall_cnt=3; resumes RUN on the ready cycle.
- MEM wait with i_pc_sel_ex=1 held throughout -> no flush during the wait; the flush is applied on the ready cycle; flush_cnt=1.
- Assert i_rst during MEM_WAIT -> next cycle state=INIT, all outputs at reset values, counters 0.
